wb_uart_tx_sequencer: RTL and testbench
=======================================

Name: wb_uart_tx_sequencer

Overview:
Wishbone master that drains a byte FIFO into the UART wishbone slave, one byte at a time.
- For each byte: writes the TX register (addr 0), waits a settle window, then polls the CTL register (addr 2) until bit0 (tx_done) reads 1.
- Frees the CPU from busy-polling the UART.
- Sits between the SoC byte producer and the UART wishbone port, which it owns exclusively.

Parameters:
DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 bytes (default 16).
SETTLE_CYCLES, 64, clk cycles waited after the TX write ack before the first CTL poll; covers slow tx_clk start-up.
TIMEOUT_POLLS, 4096, CTL reads allowed per byte before the byte is abandoned and o_err is set.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
i_push  input  1  enqueue i_data this cycle; ignored when o_full=1.
i_data  input  8  byte to enqueue.
o_full  output  1  FIFO full.
o_level  output  DEPTH_LOG2+1  FIFO occupancy.
o_busy  output  1  FSM not in IDLE, or FIFO not empty.
o_err  output  1  sticky timeout flag; cleared by reset or i_clr_err.
i_clr_err  input  1  clears o_err.
o_wb_cyc  output  1  wishbone cycle.
o_wb_stb  output  1  wishbone strobe.
o_wb_we  output  1  write enable.
o_wb_addr  output  2  register address.
o_wb_data  output  8  write data.
i_wb_ack  input  1  slave acknowledge.
i_wb_stl  input  1  slave stall.
i_wb_data  input  8  slave read data.

Behaviour:
- Reset: synchronous, active-high.
  - All outputs 0: o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_err, o_busy, o_level=0, o_full.
  - FIFO emptied; FSM to IDLE.
  - Reset mid-transaction drops cyc/stb on the next edge with no completion; the in-flight byte is lost.
- FIFO: registered, first-word-fall-through.
  - Push and pop in the same cycle: level unchanged, allowed even when full (the pop frees a slot).
  - Push when full without a pop: dropped, level unchanged.
  - Pointers wrap modulo 2**DEPTH_LOG2; level is 0..2**DEPTH_LOG2.
- Wishbone: classic pipelined single cycle.
  - stb is held until sampled with i_wb_stl=0, deasserted the following cycle.
  - cyc is held until i_wb_ack=1, deasserted the cycle after ack.
  - An ack arriving in the same cycle as the accepted stb is legal.
  - Read data is captured only on ack.
- FSM:
  - IDLE: FIFO non-empty -> pop head into byte register, go WR_REQ. Minimum one cycle spent in IDLE between bytes.
  - WR_REQ: cyc=1, stb=1, we=1, addr=0, data=byte. On stl=0 -> WR_ACK, or straight to SETTLE if ack is also seen.
  - WR_ACK: cyc=1, stb=0, we=1 (addr/data held). On ack -> SETTLE; counter loaded with SETTLE_CYCLES-1 and poll count cleared.
  - SETTLE: count down to 0 -> RD_REQ.
  - RD_REQ: cyc=1, stb=1, we=0, addr=2. On stl=0 -> RD_ACK; poll count += 1.
  - RD_ACK: on ack:
    - i_wb_data[0]=1 -> IDLE.
    - else poll count == TIMEOUT_POLLS -> set o_err, go IDLE.
    - else -> RD_REQ.
- Byte-to-byte spacing is therefore at least 1 (IDLE) + write + SETTLE_CYCLES + polls.
- i_clr_err and a timeout on the same cycle: set wins.
- Only addresses 0 and 2 are ever issued; addr 1 (RX) is never touched.

Decomposition:
- Shared package wb_uart_pkg holds:
  - Register address constants TX_REG=2'd0, RX_REG=2'd1, CTL_REG=2'd2.
  - CTL_TX_DONE_BIT=0.
  - FSM state encoding (3-bit).
- One sub-module: sync_fifo (parameterised width/depth, FWFT, level output), reusable for a future RX path.

Test Plan:
- Push 0x41 with an ideal slave (no stall, ack next cycle, CTL bit0=1 on the 3rd read) -> exactly one write addr0 data 0x41, SETTLE_CYCLES idle cycles, 3 reads of addr2, then o_busy=0.
- Push 0x10..0x1F (16 bytes, DEPTH_LOG2=4) -> o_full=1 after the 16th push; a 17th push (0x99) is dropped; slave sees 16 writes in order 0x10..0x1F, never 0x99.
- Slave asserts i_wb_stl for 5 cycles on the write -> stb held 5+1 cycles with data stable; exactly one write accepted.
- CTL bit0 held at 0, TIMEOUT_POLLS=8 -> 8 reads, then o_err=1 and the next queued byte is written; i_clr_err -> o_err=0.
- Push and pop in the same cycle at level=16 -> level stays 16, new byte accepted.
- Assert reset during WR_ACK -> next cycle o_wb_cyc=0, o_level=0, FSM IDLE; no further bus activity.

Source files
------------

// File: rtl/wb_uart_pkg.sv
// Shared definitions for the UART wishbone register map and the TX sequencer FSM.
package wb_uart_pkg;

  localparam logic [1:0] TX_REG  = 2'd0;
  localparam logic [1:0] RX_REG  = 2'd1;
  localparam logic [1:0] CTL_REG = 2'd2;

  localparam int CTL_TX_DONE_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_REQ = 3'd1,
    S_WR_ACK = 3'd2,
    S_SETTLE = 3'd3,
    S_RD_REQ = 3'd4,
    S_RD_ACK = 3'd5
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (level == '0);
  assign full    = (level == FULL_LEVEL);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/wb_uart_tx_sequencer.sv
// Wishbone master draining a byte FIFO into the UART: write TX, settle, then poll
// CTL until tx_done, abandoning the byte with a sticky error after too many polls.
module wb_uart_tx_sequencer
  import wb_uart_pkg::*;
#(
  parameter int DEPTH_LOG2    = 4,
  parameter int SETTLE_CYCLES = 64,
  parameter int TIMEOUT_POLLS = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [7:0]            i_data,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_busy,
  output logic                  o_err,
  input  logic                  i_clr_err,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [1:0]            o_wb_addr,
  output logic [7:0]            o_wb_data,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stl,
  input  logic [7:0]            i_wb_data
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = $clog2(TIMEOUT_POLLS + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] TIMEOUT_VAL = PW'(TIMEOUT_POLLS);

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [PW-1:0] poll_cnt;
  logic [PW-1:0] polls;
  logic          fifo_pop;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic          wr_done;
  logic          rd_done;
  logic          tx_done;
  logic          unused_rdata;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (i_push),
    .din   (i_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (o_full),
    .level (o_level)
  );

  assign fifo_pop = (state == S_IDLE) && !fifo_empty;
  assign o_busy   = (state != S_IDLE) || !fifo_empty;
  assign tx_done  = i_wb_data[CTL_TX_DONE_BIT];
  assign unused_rdata = ^i_wb_data;

  // An ack may coincide with the accepting (unstalled) strobe cycle.
  assign wr_done = i_wb_ack && ((state == S_WR_ACK) || (state == S_WR_REQ && !i_wb_stl));
  assign rd_done = i_wb_ack && ((state == S_RD_ACK) || (state == S_RD_REQ && !i_wb_stl));
  assign polls   = (state == S_RD_REQ) ? poll_cnt + 1'b1 : poll_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_addr  <= '0;
      o_wb_data  <= '0;
      o_err      <= 1'b0;
      settle_cnt <= '0;
      poll_cnt   <= '0;
    end else begin
      if (i_clr_err) o_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            o_wb_we   <= 1'b1;
            o_wb_addr <= TX_REG;
            o_wb_data <= fifo_dout;
            state     <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (!i_wb_stl) begin
            o_wb_stb <= 1'b0;
            state    <= S_WR_ACK;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            o_wb_we   <= 1'b0;
            o_wb_addr <= CTL_REG;
            state     <= S_RD_REQ;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_RD_REQ: begin
          if (!i_wb_stl) begin
            o_wb_stb <= 1'b0;
            poll_cnt <= poll_cnt + 1'b1;
            state    <= S_RD_ACK;
          end
        end
        S_WR_ACK, S_RD_ACK: begin
        end
        default: state <= S_IDLE;
      endcase

      // Completion handling overrides the per-state updates above.
      if (wr_done) begin
        o_wb_cyc   <= 1'b0;
        o_wb_we    <= 1'b0;
        settle_cnt <= SETTLE_LOAD;
        poll_cnt   <= '0;
        state      <= S_SETTLE;
      end

      if (rd_done) begin
        if (tx_done) begin
          o_wb_cyc <= 1'b0;
          state    <= S_IDLE;
        end else if (polls == TIMEOUT_VAL) begin
          o_wb_cyc <= 1'b0;
          o_err    <= 1'b1;
          state    <= S_IDLE;
        end else begin
          o_wb_stb <= 1'b1;
          state    <= S_RD_REQ;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_uart_tx_sequencer.sv
// Directed bench for wb_uart_tx_sequencer with a behavioural pipelined UART slave.
module tb_wb_uart_tx_sequencer;

  localparam int DL = 4;
  localparam int SC = 4;
  localparam int TP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_push = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_clr_err = 1'b0;
  logic       o_full, o_busy, o_err;
  logic [DL:0] o_level;
  logic       o_wb_cyc, o_wb_stb, o_wb_we;
  logic [1:0] o_wb_addr;
  logic [7:0] o_wb_data;
  logic       i_wb_ack = 1'b0;
  logic       i_wb_stl = 1'b0;
  logic [7:0] i_wb_data = 8'h00;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_uart_tx_sequencer #(.DEPTH_LOG2(DL), .SETTLE_CYCLES(SC), .TIMEOUT_POLLS(TP)) dut (
    .clk(clk), .reset(reset), .i_push(i_push), .i_data(i_data),
    .o_full(o_full), .o_level(o_level), .o_busy(o_busy), .o_err(o_err),
    .i_clr_err(i_clr_err), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_ack(i_wb_ack), .i_wb_stl(i_wb_stl), .i_wb_data(i_wb_data)
  );

  // Slave model knobs and observations
  int         stall_budget = 0;
  bit         stall_forever = 0;
  bit         ack_hold = 0;
  int         done_on_read = 1;
  bit         pending_ack = 0;
  bit         pending_was_write = 0;
  logic [7:0] pending_rdata = 8'h00;
  logic [7:0] write_log[$];
  int         read_total = 0, rd_count_byte = 0, bad_addr = 0, bus_cycles = 0;
  int         stb_hold = 0, last_stb_hold = 0, gap_cnt = 0, last_gap = -1;
  bit         in_gap = 0, data_changed = 0;
  logic [7:0] hold_data = 8'h00;
  int         base_idx = 0;

  // Slave drives on the falling edge; ack arrives one cycle after the accepting edge.
  always @(negedge clk) begin
    i_wb_ack = 1'b0;
    i_wb_stl = 1'b0;
    if (reset) begin
      pending_ack = 0;
      in_gap = 0;
      stb_hold = 0;
    end else begin
      if (o_wb_cyc) bus_cycles++;
      if (in_gap) begin
        if (o_wb_cyc) begin in_gap = 0; last_gap = gap_cnt; end
        else gap_cnt++;
      end
      if (pending_ack && !ack_hold) begin
        i_wb_ack = 1'b1;
        i_wb_data = pending_rdata;
        pending_ack = 0;
        if (pending_was_write) begin in_gap = 1; gap_cnt = 0; end
      end
      if (o_wb_cyc && o_wb_stb) begin
        if (o_wb_we) begin
          if (stb_hold == 0) hold_data = o_wb_data;
          else if (o_wb_data !== hold_data) data_changed = 1;
          stb_hold++;
        end
        if (stall_forever || (o_wb_we && stall_budget > 0)) begin
          i_wb_stl = 1'b1;
          if (!stall_forever) stall_budget--;
        end else begin
          pending_ack = 1;
          pending_was_write = o_wb_we;
          if (o_wb_we) begin
            if (o_wb_addr !== 2'd0) bad_addr++;
            write_log.push_back(o_wb_data);
            rd_count_byte = 0;
            last_stb_hold = stb_hold;
            stb_hold = 0;
            pending_rdata = 8'h00;
          end else begin
            if (o_wb_addr !== 2'd2) bad_addr++;
            read_total++;
            rd_count_byte++;
            pending_rdata = {7'h78, (done_on_read != 0 && rd_count_byte == done_on_read)};
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    i_push = 1'b1;
    i_data = b;
    @(negedge clk);
    i_push = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!o_busy && !o_wb_cyc) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    n_checks++; if (o_wb_cyc !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cyc: got %0b expected 0", o_wb_cyc); end
    n_checks++; if (o_wb_stb !== 1'b0 || o_wb_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stb_we: got %0b%0b expected 00", o_wb_stb, o_wb_we); end
    n_checks++; if (o_wb_addr !== 2'd0 || o_wb_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_addr_data: got %0h/%0h expected 0/0", o_wb_addr, o_wb_data); end
    n_checks++; if (o_level !== 5'd0 || o_full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_level: got %0d full %0b expected 0 full 0", o_level, o_full); end
    n_checks++; if (o_busy !== 1'b0 || o_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy_err: got %0b%0b expected 00", o_busy, o_err); end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_single_byte();
    int wl, rt;
    bit ok;
    done_on_read = 3;
    wl = write_log.size();
    rt = read_total;
    push_byte(8'h41);
    wait_idle(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL single_timeout: got busy %0b expected 0", o_busy); end
    n_checks++; if (write_log.size() !== wl + 1) begin n_fail++; $display("[TB] FAIL single_writes: got %0d expected %0d", write_log.size() - wl, 1); end
    n_checks++; if (write_log[wl] !== 8'h41) begin n_fail++; $display("[TB] FAIL single_data: got %0h expected 41", write_log[wl]); end
    n_checks++; if (last_gap !== SC) begin n_fail++; $display("[TB] FAIL single_settle_gap: got %0d expected %0d", last_gap, SC); end
    n_checks++; if (read_total - rt !== 3) begin n_fail++; $display("[TB] FAIL single_reads: got %0d expected 3", read_total - rt); end
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("[TB] FAIL single_err: got %0b expected 0", o_err); end
  endtask

  task automatic test_fill_and_drop();
    stall_forever = 1;
    done_on_read = 1;
    base_idx = write_log.size();
    push_byte(8'h0F);
    tick(2);
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    n_checks++; if (o_level !== 5'd16) begin n_fail++; $display("[TB] FAIL fill_level: got %0d expected 16", o_level); end
    n_checks++; if (o_full !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_full: got %0b expected 1", o_full); end
    push_byte(8'h99);
    n_checks++; if (o_level !== 5'd16) begin n_fail++; $display("[TB] FAIL drop_level: got %0d expected 16", o_level); end
  endtask

  task automatic test_push_pop_full();
    bit found = 0;
    i_push = 1'b1;
    i_data = 8'h20;
    stall_forever = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_wb_cyc && o_wb_stb && o_wb_we && o_wb_data == 8'h10) begin found = 1; break; end
    end
    i_push = 1'b0;
    n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL pushpop_wait: got no write of 10 expected one"); end
    n_checks++; if (o_level !== 5'd16) begin n_fail++; $display("[TB] FAIL pushpop_level: got %0d expected 16", o_level); end
  endtask

  task automatic test_drain_order();
    bit ok;
    logic [7:0] exp;
    wait_idle(3000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL drain_timeout: got busy %0b expected 0", o_busy); end
    n_checks++; if (write_log.size() - base_idx !== 18) begin n_fail++; $display("[TB] FAIL drain_count: got %0d expected 18", write_log.size() - base_idx); end
    for (int i = 0; i < 18; i++) begin
      exp = (i == 0) ? 8'h0F : 8'h0F + 8'(i);
      n_checks++;
      if (write_log[base_idx + i] !== exp) begin
        n_fail++; $display("[TB] FAIL drain_order[%0d]: got %0h expected %0h", i, write_log[base_idx + i], exp);
      end
    end
    n_checks++; if (write_log.size() > 0 && write_log[$] == 8'h99) begin n_fail++; $display("[TB] FAIL drain_dropped: got 99 expected none"); end
  endtask

  task automatic test_stall_write();
    int wl;
    bit ok;
    done_on_read = 1;
    data_changed = 0;
    stall_budget = 5;
    wl = write_log.size();
    push_byte(8'h5A);
    wait_idle(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL stall_timeout: got busy %0b expected 0", o_busy); end
    n_checks++; if (write_log.size() !== wl + 1 || write_log[wl] !== 8'h5A) begin n_fail++; $display("[TB] FAIL stall_write: got %0d writes expected 1 of 5a", write_log.size() - wl); end
    n_checks++; if (last_stb_hold !== 6) begin n_fail++; $display("[TB] FAIL stall_stb_hold: got %0d expected 6", last_stb_hold); end
    n_checks++; if (data_changed !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_data_stable: got changed expected stable"); end
  endtask

  task automatic test_timeout();
    bit found = 0;
    bit ok;
    done_on_read = 0;
    push_byte(8'h77);
    push_byte(8'h78);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (o_err) begin found = 1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL timeout_err: got %0b expected 1", o_err); end
    n_checks++; if (rd_count_byte !== TP) begin n_fail++; $display("[TB] FAIL timeout_polls: got %0d expected %0d", rd_count_byte, TP); end
    done_on_read = 1;
    wait_idle(300, ok);
    n_checks++; if (!ok || write_log[$] !== 8'h78) begin n_fail++; $display("[TB] FAIL timeout_next_byte: got %0h expected 78", write_log[$]); end
    n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_sticky: got %0b expected 1", o_err); end
    i_clr_err = 1'b1;
    tick(1);
    i_clr_err = 1'b0;
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_err: got %0b expected 0", o_err); end
  endtask

  task automatic test_reset_mid_write();
    bit found = 0;
    int bc;
    ack_hold = 1;
    push_byte(8'h33);
    push_byte(8'h34);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_wb_cyc && !o_wb_stb && o_wb_we) begin found = 1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL midreset_wr_ack: got no WR_ACK expected one"); end
    n_checks++; if (o_level !== 5'd1) begin n_fail++; $display("[TB] FAIL midreset_pre_level: got %0d expected 1", o_level); end
    reset = 1'b1;
    tick(1);
    n_checks++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_cyc: got %0b%0b expected 00", o_wb_cyc, o_wb_stb); end
    n_checks++; if (o_level !== 5'd0 || o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_level_busy: got %0d/%0b expected 0/0", o_level, o_busy); end
    tick(1);
    reset = 1'b0;
    ack_hold = 0;
    bc = bus_cycles;
    tick(30);
    n_checks++; if (bus_cycles !== bc) begin n_fail++; $display("[TB] FAIL midreset_quiet: got %0d bus cycles expected 0", bus_cycles - bc); end
    n_checks++; if (bad_addr !== 0) begin n_fail++; $display("[TB] FAIL bad_addr: got %0d expected 0", bad_addr); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_and_drop();
    test_push_pop_full();
    test_drain_order();
    test_stall_write();
    test_timeout();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
